wbu_writeback: RTL and testbench

- Writeback unit that sits directly upstream of the register-file write port.
- Accepts completed results from the execute stage over a valid/ready handshake. Non-load results are written directly.
- For loads, waits for the memory read response, then byte/half-aligns and sign- or zero-extends the data before writing.
- Exports a one-entry pending-write indication so decode can stall on read-after-write hazards.

---
 rtl/wbu_writeback.sv | 128 ++++++++++++
 tb/tb_wbu_writeback.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wbu_writeback.sv
// Writeback unit feeding the register-file write port: ALU results, aligned/extended loads, pending-write hazard flag.
// Optional 64-bit WRITE-cycle counter output commit_cnt when WBU_COMMIT_CNT_EN is defined.
module wbu_writeback #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] busy_rd,
   output logic [1:0]            state_dbg
`ifdef WBU_COMMIT_CNT_EN
   ,
   output logic [63:0]           commit_cnt
`endif
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("wbu_writeback supports DATA_WIDTH == 32 only");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   state_t                  state, state_d;
   logic [ADDR_WIDTH-1:0]   held_rd;
   logic [DATA_WIDTH-1:0]   held_data;
   logic [1:0]              held_addr;
   logic [2:0]              held_f3;
   logic [DATA_WIDTH-1:0]   load_val;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic                    accept;

   // Handshake: a result transfers on the rising edge where in_valid && in_ready;
   // in_ready depends only on state, so the producer may hold in_valid until accepted.
   assign in_ready  = (state != WAIT_MEM);
   assign accept    = in_valid && in_ready;
   assign state_dbg = state;

   always_comb begin
      state_d = state;
      case (state)
         IDLE, WRITE: begin
            if (accept) state_d = in_is_load ? WAIT_MEM : WRITE;
            else        state_d = IDLE;
         end
         WAIT_MEM: if (mem_rvalid) state_d = WRITE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Lane selection from the word-aligned response; unknown funct3 falls back to a full word.
   always_comb begin
      byte_sel = 8'h00;
      case (held_addr)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = held_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_val = mem_rdata;
      case (held_f3)
         3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_rd   <= '0;
         held_data <= '0;
         held_addr <= 2'd0;
         held_f3   <= 3'd0;
      end else begin
         if (state != WAIT_MEM) begin
            if (accept) begin
               held_rd <= in_rd;
               if (in_is_load) begin
                  held_addr <= in_data[1:0];
                  held_f3   <= in_funct3;
               end else begin
                  held_data <= in_data;
               end
            end
         end else if (mem_rvalid) begin
            held_data <= load_val;
         end
      end
   end

   assign rf_wen   = (state == WRITE) && (held_rd != '0);
   assign rf_waddr = held_rd;
   assign rf_wdata = held_data;
   assign busy     = (state == WAIT_MEM) || rf_wen;
   assign busy_rd  = busy ? held_rd : '0;

`ifdef WBU_COMMIT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 commit_cnt <= 64'd0;
      else if (state == WRITE) commit_cnt <= commit_cnt + 64'd1;
   end
`endif

endmodule

// File: tb/tb_wbu_writeback.sv
// Directed self-checking bench for wbu_writeback: inputs driven and outputs sampled on the falling edge.
module tb_wbu_writeback;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy;
   logic [4:0]  busy_rd;
   logic [1:0]  state_dbg;
`ifdef WBU_COMMIT_CNT_EN
   logic [63:0] commit_cnt;
   logic [63:0] cnt_before;
`endif

   int tests_run = 0;
   int fails     = 0;

   localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_WRITE = 2'd2;

   wbu_writeback dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
      .in_is_load(in_is_load), .in_funct3(in_funct3),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .busy_rd(busy_rd), .state_dbg(state_dbg)
`ifdef WBU_COMMIT_CNT_EN
      , .commit_cnt(commit_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers
   task automatic drive_result(input logic [4:0] rd, input logic [31:0] d,
                               input logic ld, input logic [2:0] f3);
      in_valid = 1'b1; in_rd = rd; in_data = d; in_is_load = ld; in_funct3 = f3;
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; in_rd = 5'd0; in_data = 32'd0; in_is_load = 1'b0; in_funct3 = 3'd0;
   endtask

   task automatic test_reset();
      // bring DUT into WRITE with non-zero held values, then reset between edges
      @(negedge clk); drive_result(5'd9, 32'hCAFEF00D, 1'b0, 3'd0);
      @(negedge clk); drive_idle();
      tests_run++; if (rf_wen !== 1'b1) begin fails++; $display("FAIL rst_pre_wen: got %0b want 1", rf_wen); end
      #1 rst = 1'b1;
      #1;
      tests_run++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rst_wen: got %0b want 0", rf_wen); end
      tests_run++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL rst_waddr: got %0d want 0", rf_waddr); end
      tests_run++; if (rf_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata: got %h want 0", rf_wdata); end
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
      tests_run++; if (busy_rd !== 5'd0) begin fails++; $display("FAIL rst_busy_rd: got %0d want 0", busy_rd); end
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
      tests_run++; if (state_dbg !== S_IDLE) begin fails++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
`ifdef WBU_COMMIT_CNT_EN
      tests_run++; if (commit_cnt !== 64'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", commit_cnt); end
`endif
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_alu_write();
      @(negedge clk); drive_result(5'd5, 32'h12345678, 1'b0, 3'd0);
      @(negedge clk); drive_idle();
      tests_run++; if (rf_wen !== 1'b1) begin fails++; $display("FAIL alu_wen: got %0b want 1", rf_wen); end
      tests_run++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr); end
      tests_run++; if (rf_wdata !== 32'h12345678) begin fails++; $display("FAIL alu_wdata: got %h want 12345678", rf_wdata); end
      tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL alu_busy: got %0b want 1", busy); end
      tests_run++; if (busy_rd !== 5'd5) begin fails++; $display("FAIL alu_busy_rd: got %0d want 5", busy_rd); end
      @(negedge clk);
      tests_run++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL alu_wen_after: got %0b want 0", rf_wen); end
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL alu_busy_after: got %0b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); drive_result(5'd1, 32'h0000000A, 1'b0, 3'd0);
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %0b want 1", in_ready); end
      tests_run++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hA) begin
         fails++; $display("FAIL b2b_first: got wen=%0b a=%0d d=%h want wen=1 a=1 d=0000000a", rf_wen, rf_waddr, rf_wdata); end
      drive_result(5'd2, 32'h0000000B, 1'b0, 3'd0);
      @(negedge clk); drive_idle();
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2: got %0b want 1", in_ready); end
      tests_run++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'hB) begin
         fails++; $display("FAIL b2b_second: got wen=%0b a=%0d d=%h want wen=1 a=2 d=0000000b", rf_wen, rf_waddr, rf_wdata); end
      @(negedge clk);
      tests_run++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL b2b_end: got %0b want 0", rf_wen); end
   endtask

   task automatic run_load(input string name, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] rdata, input logic [31:0] exp);
      @(negedge clk); drive_result(rd, addr, 1'b1, f3);
      @(negedge clk); drive_idle();
      tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1 || busy_rd !== rd || rf_wen !== 1'b0) begin
         fails++; $display("FAIL %s_wait: got rdy=%0b busy=%0b brd=%0d wen=%0b want rdy=0 busy=1 brd=%0d wen=0",
                           name, in_ready, busy, busy_rd, rf_wen, rd); end
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL %s_hold: got rdy=%0b want 0", name, in_ready); end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk); mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tests_run++; if (rf_wen !== 1'b1 || rf_waddr !== rd || rf_wdata !== exp) begin
         fails++; $display("FAIL %s_data: got wen=%0b a=%0d d=%h want wen=1 a=%0d d=%h",
                           name, rf_wen, rf_waddr, rf_wdata, rd, exp); end
      @(negedge clk);
      tests_run++; if (rf_wen !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL %s_done: got wen=%0b rdy=%0b want wen=0 rdy=1", name, rf_wen, in_ready); end
   endtask

   task automatic test_loads();
      run_load("lb",  5'd3,  32'h00001003, 3'b000, 32'h80FF0000, 32'hFFFFFF80);
      run_load("lhu", 5'd4,  32'h00001002, 3'b101, 32'hBEEF1234, 32'h0000BEEF);
      run_load("lh",  5'd6,  32'h00002001, 3'b001, 32'h12348001, 32'hFFFF8001);
      run_load("lbu", 5'd8,  32'h00000001, 3'b100, 32'h0000F100, 32'h000000F1);
      run_load("lw",  5'd10, 32'h00000000, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
      run_load("f3x", 5'd11, 32'h00000003, 3'b111, 32'h80000001, 32'h80000001);
   endtask

   task automatic test_rd_zero();
`ifdef WBU_COMMIT_CNT_EN
      @(negedge clk); cnt_before = commit_cnt;
`endif
      @(negedge clk); drive_result(5'd0, 32'h0000DEAD, 1'b0, 3'd0);
      @(negedge clk); drive_idle();
      tests_run++; if (state_dbg !== S_WRITE) begin fails++; $display("FAIL rd0_state: got %0d want 2", state_dbg); end
      tests_run++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rd0_wen: got %0b want 0", rf_wen); end
      tests_run++; if (busy !== 1'b0 || busy_rd !== 5'd0) begin fails++; $display("FAIL rd0_busy: got %0b/%0d want 0/0", busy, busy_rd); end
      @(negedge clk);
`ifdef WBU_COMMIT_CNT_EN
      tests_run++; if (commit_cnt !== cnt_before + 64'd1) begin
         fails++; $display("FAIL rd0_cnt: got %0d want %0d", commit_cnt, cnt_before + 64'd1); end
`endif
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk); drive_result(5'd7, 32'h00000002, 1'b1, 3'b000);
      @(negedge clk); drive_idle();
      tests_run++; if (state_dbg !== S_WAIT) begin fails++; $display("FAIL rw_state_wait: got %0d want 1", state_dbg); end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h00FF0000;
      @(negedge clk); mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tests_run++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rw_wen: got %0b want 0", rf_wen); end
      tests_run++; if (state_dbg !== S_IDLE) begin fails++; $display("FAIL rw_state: got %0d want 0", state_dbg); end
      tests_run++; if (busy !== 1'b0 || busy_rd !== 5'd0) begin fails++; $display("FAIL rw_busy: got %0b/%0d want 0/0", busy, busy_rd); end
      @(negedge clk);
      tests_run++; if (rf_wen !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL rw_after: got wen=%0b rdy=%0b want 0/1", rf_wen, in_ready); end
   endtask

   initial begin
      rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_alu_write();
      test_back_to_back();
      test_loads();
      test_rd_zero();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion want finish before 100000");
      $fatal(1, "timeout");
   end
endmodule
